// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the GMII receive/transmit paths.
package eth_pkg;

    localparam logic [7:0]  PREAM       = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        RX_DROP     = 2'd0,
        RX_IDLE     = 2'd1,
        RX_PREAMBLE = 2'd2,
        RX_DATA     = 2'd3
    } rx_state_t;

    localparam int unsigned STAT_CRC_OK   = 32'd0;
    localparam int unsigned STAT_ERR      = 32'd1;
    localparam int unsigned STAT_RUNT     = 32'd2;
    localparam int unsigned STAT_OVERSIZE = 32'd3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 (LSB of the data byte first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c_s;

    // Eight serial LFSR steps unrolled into one byte update.
    always_comb begin
        c_s = crc;
        for (int i = 0; i < 8; i++) begin
            c_s = (c_s >> 1) ^ (CRC_POLY & {32{c_s[0] ^ data[i]}});
        end
        crc_next = c_s;
    end

endmodule

// File: rtl/gmii_rx.sv
// GMII receive front end: strips preamble/SFD, checks FCS and length, and writes
// 9-bit words {1, byte} per data byte followed by one {0, status} trailer per frame.
module gmii_rx
    import eth_pkg::*;
#(
    parameter bit          STRIP_FCS = 1'b1,
    parameter int unsigned MAX_LEN   = 32'd1518,
    parameter int unsigned MIN_LEN   = 32'd64
) (
    input  logic       phy_rx_clk,
    input  logic       sys_rst_n,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    input  logic [7:0] phy_rxd,
    output logic       rx_wr_en,
    output logic [8:0] rx_wr_data
);

    localparam int unsigned FCS_HOLD = STRIP_FCS ? 32'd4 : 32'd0;
    // Bytes still parked in the delay line are indexed FCS_HOLD behind the count.
    localparam logic [13:0] WR_LIMIT = 14'(MAX_LEN + FCS_HOLD);
    localparam logic [13:0] MIN_L    = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L    = 14'(MAX_LEN);
    localparam logic [12:0] CNT_SAT  = 13'h1FFF;

    logic            dv_q;
    logic            er_q;
    logic [7:0]      rxd_q;

    rx_state_t       state_r, state_s;
    logic [31:0]     crc_r, crc_s, crc_calc_s;
    logic [12:0]     cnt_r, cnt_s;
    logic            err_r, err_s;
    logic [3:0][7:0] dl_r, dl_s;
    logic [2:0]      fill_r, fill_s;
    logic            wr_en_s;
    logic [8:0]      wr_data_s;
    logic            wr_ok_s;
    logic [7:0]      status_s;

    crc32_d8 u_crc (
        .crc      (crc_r),
        .data     (rxd_q),
        .crc_next (crc_calc_s)
    );

    // Input register; dv_q resets high so DROP waits for a genuine end of carrier.
    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dv_q  <= 1'b1;
            er_q  <= 1'b0;
            rxd_q <= 8'h00;
        end else begin
            dv_q  <= phy_rx_dv;
            er_q  <= phy_rx_er;
            rxd_q <= phy_rxd;
        end
    end

    assign wr_ok_s = ({1'b0, cnt_r} < WR_LIMIT);

    // Trailer status from the frame just closed.
    always_comb begin
        status_s                = 8'h00;
        status_s[STAT_CRC_OK]   = (crc_r == CRC_RESIDUE);
        status_s[STAT_ERR]      = err_r;
        status_s[STAT_RUNT]     = ({1'b0, cnt_r} < MIN_L);
        status_s[STAT_OVERSIZE] = ({1'b0, cnt_r} > MAX_L);
    end

    // Next-state, datapath and output-word logic.
    always_comb begin
        state_s   = state_r;
        crc_s     = crc_r;
        cnt_s     = cnt_r;
        err_s     = err_r;
        dl_s      = dl_r;
        fill_s    = fill_r;
        wr_en_s   = 1'b0;
        wr_data_s = rx_wr_data;

        case (state_r)
            RX_DROP: begin
                if (!dv_q) begin
                    state_s = RX_IDLE;
                end else begin
                    state_s = RX_DROP;
                end
            end
            RX_IDLE, RX_PREAMBLE: begin
                if (dv_q && (rxd_q == SFD)) begin
                    state_s = RX_DATA;
                    crc_s   = CRC_INIT;
                    cnt_s   = 13'd0;
                    err_s   = 1'b0;
                    dl_s    = 32'h0000_0000;
                    fill_s  = 3'd0;
                end else if (dv_q && (rxd_q == PREAM)) begin
                    state_s = RX_PREAMBLE;
                end else if (dv_q || (state_r == RX_PREAMBLE)) begin
                    state_s = RX_DROP;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (dv_q) begin
                    crc_s = crc_calc_s;
                    cnt_s = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + 13'd1);
                    err_s = err_r | er_q;
                    if (STRIP_FCS) begin
                        dl_s = {dl_r[2:0], rxd_q};
                        if (fill_r == 3'd4) begin
                            fill_s    = fill_r;
                            wr_en_s   = wr_ok_s;
                            wr_data_s = wr_ok_s ? {1'b1, dl_r[3]} : rx_wr_data;
                        end else begin
                            fill_s = fill_r + 3'd1;
                        end
                    end else begin
                        wr_en_s   = wr_ok_s;
                        wr_data_s = wr_ok_s ? {1'b1, rxd_q} : rx_wr_data;
                    end
                end else begin
                    wr_en_s   = 1'b1;
                    wr_data_s = {1'b0, status_s};
                    dl_s      = 32'h0000_0000;
                    fill_s    = 3'd0;
                    state_s   = RX_IDLE;
                end
            end
            default: begin
                state_s = RX_DROP;
            end
        endcase
    end

    // State, CRC, counters, delay line and registered FIFO write port.
    always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= RX_DROP;
            crc_r      <= CRC_INIT;
            cnt_r      <= 13'd0;
            err_r      <= 1'b0;
            dl_r       <= 32'h0000_0000;
            fill_r     <= 3'd0;
            rx_wr_en   <= 1'b0;
            rx_wr_data <= 9'h000;
        end else begin
            state_r    <= state_s;
            crc_r      <= crc_s;
            cnt_r      <= cnt_s;
            err_r      <= err_s;
            dl_r       <= dl_s;
            fill_r     <= fill_s;
            rx_wr_en   <= wr_en_s;
            rx_wr_data <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_gmii_rx.sv
// Scoreboard bench for gmii_rx: expected FIFO words are queued as frames are built
// and popped by a monitor whenever the DUT writes.
module tb_gmii_rx;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] rxd;
    logic       rx_wr_en;
    logic [8:0] rx_wr_data;

    int         n_cmp = 0;
    int         n_bad = 0;
    string      cur_test = "init";
    logic [8:0] exp_q[$];
    logic [7:0] frm[$];

    gmii_rx #(
        .STRIP_FCS (1'b1),
        .MAX_LEN   (32'd1518),
        .MIN_LEN   (32'd64)
    ) dut (
        .phy_rx_clk (clk),
        .sys_rst_n  (sys_rst_n),
        .phy_rx_dv  (rx_dv),
        .phy_rx_er  (rx_er),
        .phy_rxd    (rxd),
        .rx_wr_en   (rx_wr_en),
        .rx_wr_data (rx_wr_data)
    );

    always #4 clk = ~clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Preamble, SFD, payload (base+i), FCS with optional corruption of its last byte.
    task automatic make_frame(input int plen, input int base, input logic [7:0] fcs_xor);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'(base + i);
            frm.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24] ^ fcs_xor);
    endtask

    // FCS is stripped; only the first 1518 frame bytes may ever be written.
    task automatic expect_words(input int plen, input int base);
        for (int i = 0; i < plen && i < 1518; i++) exp_q.push_back({1'b1, 8'(base + i)});
    endtask

    task automatic drive_frame(input int er_idx);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rxd   = frm[i];
            rx_er = (i == er_idx);
        end
        @(negedge clk);
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 8'h00;
    endtask

    task automatic scoreboard_mon();
        logic [8:0] exp_w;
        forever begin
            @(negedge clk);
            if (rx_wr_en !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: unexpected write en=%b data=%h, expected none", cur_test, rx_wr_en, rx_wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (rx_wr_data !== exp_w) begin
                        n_bad++;
                        $display("FAIL %s: word got %h expected %h", cur_test, rx_wr_data, exp_w);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rx_wr_en !== 1'b0 || rx_wr_data !== 9'h000) begin
            n_bad++;
            $display("FAIL reset: en=%b data=%h expected 0/000", rx_wr_en, rx_wr_data);
        end
        sys_rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (rx_wr_en !== 1'b0 || rx_wr_data !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_idle: en=%b data=%h expected 0/000", rx_wr_en, rx_wr_data);
        end
    endtask

    task automatic test_good_frame();
        cur_test = "good_frame";
        make_frame(60, 0, 8'h00);
        expect_words(60, 0);
        exp_q.push_back(9'h001);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL good_frame: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_bad_fcs();
        cur_test = "bad_fcs";
        make_frame(60, 0, 8'h01);
        expect_words(60, 0);
        exp_q.push_back(9'h000);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bad_fcs: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_rx_error();
        cur_test = "rx_error";
        make_frame(60, 0, 8'h00);
        expect_words(60, 0);
        exp_q.push_back(9'h003);
        drive_frame(8 + 10);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rx_error: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_runt();
        cur_test = "runt";
        make_frame(16, 8'h20, 8'h00);
        expect_words(16, 8'h20);
        exp_q.push_back(9'h005);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL runt: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_oversize();
        cur_test = "oversize";
        make_frame(1596, 0, 8'h00);
        expect_words(1596, 0);
        exp_q.push_back(9'h009);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL oversize: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        make_frame(60, 8'h10, 8'h00);
        expect_words(60, 8'h10);
        exp_q.push_back(9'h001);
        drive_frame(-1);
        make_frame(60, 8'h90, 8'h00);
        expect_words(60, 8'h90);
        exp_q.push_back(9'h001);
        drive_frame(-1);
        repeat (3) @(negedge clk);
        frm.delete();
        frm.push_back(8'h55); frm.push_back(8'h12); frm.push_back(8'h55);
        frm.push_back(8'hD5); frm.push_back(8'h01); frm.push_back(8'h02);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        cur_test = "reset_mid";
        make_frame(60, 0, 8'h00);
        expect_words(60, 0);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rxd   = frm[i];
            if (i == 30) begin
                sys_rst_n = 1'b0;
                #1;
                n_cmp++;
                if (rx_wr_en !== 1'b0 || rx_wr_data !== 9'h000) begin
                    n_bad++;
                    $display("FAIL reset_mid: en=%b data=%h expected 0/000", rx_wr_en, rx_wr_data);
                end
                exp_q.delete();
            end
            if (i == 34) sys_rst_n = 1'b1;
        end
        @(negedge clk);
        rx_dv = 1'b0;
        rxd   = 8'h00;
        repeat (10) @(negedge clk);
        cur_test = "after_reset";
        make_frame(60, 8'h80, 8'h00);
        expect_words(60, 8'h80);
        exp_q.push_back(9'h001);
        drive_frame(-1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL after_reset: %0d words missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rx_dv     = 1'b0;
        rx_er     = 1'b0;
        rxd       = 8'h00;
        fork
            scoreboard_mon();
        join_none
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_rx_error();
        test_runt();
        test_oversize();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
